// File: rtl/rv32i_clint_defs.sv
// Shared CLINT register map, reset constants and address decode.
// The software headers and the testbench use the same offsets.
package rv32i_clint_defs;

    localparam logic [31:0] CLINT_MSIP        = 32'h0000_0000;
    localparam logic [31:0] CLINT_MTIMECMP_LO = 32'h0000_4000;
    localparam logic [31:0] CLINT_MTIMECMP_HI = 32'h0000_4004;
    localparam logic [31:0] CLINT_MTIME_LO    = 32'h0000_BFF8;
    localparam logic [31:0] CLINT_MTIME_HI    = 32'h0000_BFFC;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } reg_sel_e;

    // Byte address to register; the low two bits never select anything.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        logic [31:0] word;
        word = addr & ~32'h3;
        case (word)
            CLINT_MSIP:        return SEL_MSIP;
            CLINT_MTIMECMP_LO: return SEL_CMP_LO;
            CLINT_MTIMECMP_HI: return SEL_CMP_HI;
            CLINT_MTIME_LO:    return SEL_MTIME_LO;
            CLINT_MTIME_HI:    return SEL_MTIME_HI;
            default:           return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_clint_if.sv
// Single-cycle memory-mapped slave port: strobe in, ack with read data one cycle later.
interface rv32i_clint_if #(
    parameter int ADDR_W = 16
);
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output stb, we, addr, wdata, input ack, rdata);
    modport slave  (input stb, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/rv32i_clint_timer.sv
// Prescaler plus 64-bit MTIME with per-half software load; frozen while i_halt is high.
module rv32i_clint_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_halt,
    input  logic        i_load_lo,
    input  logic        i_load_hi,
    input  logic [31:0] i_load_data,
    output logic [63:0] o_mtime
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [63:0]     mtime_q, mtime_d;
    logic            tick;

    always_comb begin
        // NOTE: every variable gets its default before any condition, so no path leaves one unassigned and no latch is inferred.
        tick    = !i_halt && (ps_q == PS_LAST);
        ps_d    = ps_q;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (!i_halt) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end
        // A software load suppresses this cycle's increment and any carry between halves.
        if (i_load_lo || i_load_hi) begin
            mtime_d = mtime_q;
        end
        if (i_load_lo) begin
            mtime_d[31:0] = i_load_data;
        end
        if (i_load_hi) begin
            mtime_d[63:32] = i_load_data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps_q    <= '0;
            mtime_q <= '0;
        end else begin
            ps_q    <= ps_d;
            mtime_q <= mtime_d;
        end
    end

    assign o_mtime = mtime_q;
endmodule

// File: rtl/rv32i_clint.sv
// Core-local interruptor: bus decode, MSIP, MTIMECMP, timer compare and registered IRQ outputs.
module rv32i_clint
    import rv32i_clint_defs::*;
#(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_halt,
    rv32i_clint_if.slave bus,
    output logic         o_software_interrupt,
    output logic         o_timer_interrupt
);
    logic [ADDR_W-1:0] addr;
    reg_sel_e          sel;
    logic              wr, rd;
    logic [63:0]       mtime;

    logic        msip_q, msip_d;
    logic [63:0] cmp_q, cmp_d;
    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tirq_q, tirq_d;

    assign addr = bus.addr;
    assign sel  = decode_addr(32'(addr));
    assign wr   = bus.stb && bus.we;
    assign rd   = bus.stb && !bus.we;

    rv32i_clint_timer #(.PRESCALE(PRESCALE)) u_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_halt      (i_halt),
        .i_load_lo   (wr && (sel == SEL_MTIME_LO)),
        .i_load_hi   (wr && (sel == SEL_MTIME_HI)),
        .i_load_data (bus.wdata),
        .o_mtime     (mtime)
    );

    always_comb begin
        msip_d  = msip_q;
        cmp_d   = cmp_q;
        ack_d   = bus.stb;
        rdata_d = '0;
        tirq_d  = (mtime >= cmp_q);
        if (wr) begin
            case (sel)
                SEL_MSIP:   msip_d        = bus.wdata[0];
                SEL_CMP_LO: cmp_d[31:0]   = bus.wdata;
                SEL_CMP_HI: cmp_d[63:32]  = bus.wdata;
                default:    ;
            endcase
        end
        // Read data is the register value in the strobe cycle, presented with the ack.
        if (rd) begin
            case (sel)
                SEL_MSIP:     rdata_d = {31'b0, msip_q};
                SEL_CMP_LO:   rdata_d = cmp_q[31:0];
                SEL_CMP_HI:   rdata_d = cmp_q[63:32];
                SEL_MTIME_LO: rdata_d = mtime[31:0];
                SEL_MTIME_HI: rdata_d = mtime[63:32];
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            msip_q  <= 1'b0;
            cmp_q   <= MTIMECMP_RESET;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            tirq_q  <= 1'b0;
        end else begin
            msip_q  <= msip_d;
            cmp_q   <= cmp_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            tirq_q  <= tirq_d;
        end
    end

    assign bus.ack              = ack_q;
    assign bus.rdata            = rdata_q;
    assign o_software_interrupt = msip_q;
    assign o_timer_interrupt    = tirq_q;
endmodule
